// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch prefetch unit: redirect source
// selects, fetch FSM states and the default exception vector.
package fetch_pkg;

  typedef enum logic [1:0] {
    SEL_IMD  = 2'b00,
    SEL_REGA = 2'b01,
    SEL_INDX = 2'b10,
    SEL_EXC  = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } state_t;

  localparam int unsigned EXC_PC_DEFAULT = 64;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {next_pc, instruction} entries; flush empties
// it in one cycle and wins over push/pop.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with a prefetch queue feeding the IF/ID register.
// Optional FETCH_PREFETCH_PERF_EN adds fetch and bubble counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_PC_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_if_stall,
  input  logic              fw_if_id_stall,
  input  logic              id_if_selfontepc,
  input  logic [1:0]        id_if_seltipopc,
  input  logic [ADDR_W-1:0] id_if_rega,
  input  logic [ADDR_W-1:0] id_if_pcimd2ext,
  input  logic [ADDR_W-1:0] id_if_pcindx,
  output logic [ADDR_W-1:0] if_id_proximopc,
  output logic [DATA_W-1:0] if_id_instrucao,
  output logic              if_gdm_en,
  output logic [ADDR_W-1:0] if_gdm_addr,
  input  logic              gdm_if_ack,
  input  logic [DATA_W-1:0] gdm_if_data,
`ifdef FETCH_PREFETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output logic [1:0]        dbg_state
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next4;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic [ENT_W-1:0]  q_rdata;

  assign redirect = id_if_selfontepc;
  assign pc_next4 = pc + ADDR_W'(4);

  always_comb begin
    target = EXC_PC;
    case (id_if_seltipopc)
      SEL_IMD:  target = id_if_pcimd2ext;
      SEL_REGA: target = id_if_rega;
      SEL_INDX: target = id_if_pcindx;
      default:  target = EXC_PC;
    endcase
  end

  // Memory handshake: if_gdm_en/if_gdm_addr stay stable until a cycle with
  // gdm_if_ack; that cycle completes the transfer and gdm_if_data is valid only then.
  assign push = (state == ST_WAIT) && gdm_if_ack && !redirect;
  assign pop  = !fw_if_id_stall && !redirect && !ex_if_stall && !q_empty;

  fetch_queue #(
    .DEPTH(DEPTH),
    .WIDTH(ENT_W)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_data({pc_next4, gdm_if_data}),
    .pop      (pop),
    .pop_data (q_rdata),
    .empty    (q_empty),
    .full     (q_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      if_gdm_en   <= 1'b0;
      if_gdm_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            pc <= target;
          end else if (!q_full) begin
            // IDLE has no request in flight, so one free slot covers the new one.
            state       <= ST_WAIT;
            if_gdm_en   <= 1'b1;
            if_gdm_addr <= pc;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            pc <= target;
            if (gdm_if_ack) begin
              state     <= ST_IDLE;
              if_gdm_en <= 1'b0;
            end else begin
              state <= ST_DROP;
            end
          end else if (gdm_if_ack) begin
            pc        <= pc_next4;
            state     <= ST_IDLE;
            if_gdm_en <= 1'b0;
          end
        end
        ST_DROP: begin
          if (redirect) pc <= target;
          if (gdm_if_ack) begin
            state     <= ST_IDLE;
            if_gdm_en <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          if_gdm_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_id_proximopc <= '0;
      if_id_instrucao <= '0;
    end else if (fw_if_id_stall) begin
      if_id_proximopc <= if_id_proximopc;
      if_id_instrucao <= if_id_instrucao;
    end else if (redirect) begin
      if_id_proximopc <= target;
      if_id_instrucao <= '0;
    end else if (ex_if_stall || q_empty) begin
      if_id_proximopc <= pc;
      if_id_instrucao <= '0;
    end else begin
      {if_id_proximopc, if_id_instrucao} <= q_rdata;
    end
  end

`ifdef FETCH_PREFETCH_PERF_EN
  logic bubble_wr;

  assign bubble_wr = !fw_if_id_stall && (redirect || ex_if_stall || q_empty);
  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (push)      perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (bubble_wr) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign dbg_state = state;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: memory responder, scoreboard of delivered
// IF/ID entries, and phase-by-phase directed checks.
module tb_fetch_prefetch;

  logic        clock;
  logic        reset;
  logic        ex_if_stall;
  logic        fw_if_id_stall;
  logic        id_if_selfontepc;
  logic [1:0]  id_if_seltipopc;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_pcindx;
  logic [31:0] if_id_proximopc;
  logic [31:0] if_id_instrucao;
  logic        if_gdm_en;
  logic [31:0] if_gdm_addr;
  logic        gdm_if_ack;
  logic [31:0] gdm_if_data;
  logic [1:0]  dbg_state;
`ifdef FETCH_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] req_log[$];
  int          mem_lat = 0;
  bit          const_mode = 1'b1;
  bit          dead_next = 1'b0;
  bit          dead_seen = 1'b0;

  fetch_prefetch dut (
    .clock           (clock),
    .reset           (reset),
    .ex_if_stall     (ex_if_stall),
    .fw_if_id_stall  (fw_if_id_stall),
    .id_if_selfontepc(id_if_selfontepc),
    .id_if_seltipopc (id_if_seltipopc),
    .id_if_rega      (id_if_rega),
    .id_if_pcimd2ext (id_if_pcimd2ext),
    .id_if_pcindx    (id_if_pcindx),
    .if_id_proximopc (if_id_proximopc),
    .if_id_instrucao (if_id_instrucao),
    .if_gdm_en       (if_gdm_en),
    .if_gdm_addr     (if_gdm_addr),
    .gdm_if_ack      (gdm_if_ack),
    .gdm_if_data     (gdm_if_data),
`ifdef FETCH_PREFETCH_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
`endif
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_mode) return 32'h0000000B;
    return {8'hC0, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({a + 32'd4, mem_word(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic wait_req(input int base, input logic [31:0] exp, input string name);
    int n;
    n = 0;
    while (req_log.size() <= base && n < 60) begin
      @(posedge clock);
      n++;
    end
    if (req_log.size() <= base) begin
      checks++;
      errors++;
      $display("FAIL %s: no request seen, expected addr %h", name, exp);
    end else begin
      check(name, {32'd0, req_log[base]}, {32'd0, exp});
    end
  endtask

  task automatic wait_delivery(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (if_id_instrucao == 32'd0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (if_id_instrucao == 32'd0) begin
      checks++;
      errors++;
      $display("FAIL %s: no instruction delivered within bound", name);
    end
  endtask

  // Wait (bounded) for the first cycle of a fresh request; returns its log index.
  task automatic wait_new_req(output int idx);
    int n;
    n = 0;
    @(posedge clock); #2;
    while (if_gdm_en && n < 20) begin @(posedge clock); #2; n++; end
    idx = req_log.size();
    n = 0;
    while (req_log.size() <= idx && n < 40) begin @(posedge clock); #2; n++; end
    if (req_log.size() <= idx) begin
      checks++;
      errors++;
      $display("FAIL new_req: no request started within bound");
    end
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] tgt, input bit mode,
                          input string name, output int base);
    @(posedge clock); #2;
    const_mode       = mode;
    id_if_selfontepc = 1'b1;
    id_if_seltipopc  = sel;
    id_if_rega       = $urandom;
    id_if_pcimd2ext  = $urandom;
    id_if_pcindx     = $urandom;
    case (sel)
      2'b00:   id_if_pcimd2ext = tgt;
      2'b01:   id_if_rega      = tgt;
      2'b10:   id_if_pcindx    = tgt;
      default: ;
    endcase
    base = req_log.size();
    @(posedge clock); #1;
    exp_q.delete();
    push_stream(tgt);
    #1;
    id_if_selfontepc = 1'b0;
    @(negedge clock);
    check({name, "_bubble_instr"}, {32'd0, if_id_instrucao}, 64'd0);
    check({name, "_bubble_pc"}, {32'd0, if_id_proximopc}, {32'd0, tgt});
    wait_req(base, tgt, {name, "_addr"});
  endtask

  // Memory responder: acks after mem_lat wait cycles, logs each new request address.
  initial begin
    int   cnt;
    logic en_prev;
    cnt = 0;
    en_prev = 1'b0;
    gdm_if_ack = 1'b0;
    gdm_if_data = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        gdm_if_ack = 1'b0;
        cnt = 0;
        en_prev = 1'b0;
      end else begin
        if (if_gdm_en && !en_prev) req_log.push_back(if_gdm_addr);
        if (if_gdm_en && cnt >= mem_lat) begin
          gdm_if_ack  = 1'b1;
          gdm_if_data = dead_next ? 32'h0000DEAD : mem_word(if_gdm_addr);
          dead_next   = 1'b0;
          cnt = 0;
        end else begin
          gdm_if_ack = 1'b0;
          cnt = if_gdm_en ? cnt + 1 : 0;
        end
        en_prev = if_gdm_en;
      end
    end
  end

  // Scoreboard monitor: every fresh IF/ID instruction must match the expected stream.
  initial begin
    bit hold_prev;
    hold_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        if (if_id_instrucao == 32'h0000DEAD) dead_seen = 1'b1;
        if (!hold_prev && if_id_instrucao != 32'd0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %h/%h with empty expected queue",
                     if_id_proximopc, if_id_instrucao);
          end else begin
            check("sb_ifid", {if_id_proximopc, if_id_instrucao}, exp_q.pop_front());
          end
        end
        hold_prev = fw_if_id_stall;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int          base;
    logic [31:0] hold_addr;
    logic [31:0] rec_pc;
    logic [31:0] rec_instr;
    int          n;

    reset            = 1'b1;
    ex_if_stall      = 1'b0;
    fw_if_id_stall   = 1'b0;
    id_if_selfontepc = 1'b0;
    id_if_seltipopc  = 2'b00;
    id_if_rega       = '0;
    id_if_pcimd2ext  = '0;
    id_if_pcindx     = '0;

    repeat (3) @(posedge clock);
    #2;
    check("rst_en", {63'd0, if_gdm_en}, 64'd0);
    check("rst_addr", {32'd0, if_gdm_addr}, 64'd0);
    check("rst_pc", {32'd0, if_id_proximopc}, 64'd0);
    check("rst_instr", {32'd0, if_id_instrucao}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);

    // Phase A: constant 0x0B memory, same-cycle ack
    const_mode = 1'b1;
    push_stream(32'h0);
    reset = 1'b0;
    wait_delivery("first_deliv");
    check("first_instr", {32'd0, if_id_instrucao}, 64'h0B);
    check("first_pc", {32'd0, if_id_proximopc}, 64'd4);
    wait_req(0, 32'h0, "seq_addr0");
    wait_req(1, 32'h4, "seq_addr1");
    wait_req(2, 32'h8, "seq_addr2");
    repeat (4) @(posedge clock);

    // Phase C: redirect to exception vector, then to register target
    redirect(2'b11, 32'd64, 1'b0, "redir_exc", base);
    repeat (6) @(posedge clock);
    redirect(2'b01, 32'd23, 1'b0, "redir_rega", base);
    repeat (4) @(posedge clock);

    // Phase B: execute stall fills the queue, then drains back-to-back
    @(posedge clock); #2;
    ex_if_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("exstall_bubble", {32'd0, if_id_instrucao}, 64'd0);
    end
    check("exstall_full_en", {63'd0, if_gdm_en}, 64'd0);
    ex_if_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("exstall_drain", {63'd0, (if_id_instrucao != 32'd0)}, 64'd1);
    end
    repeat (4) @(posedge clock);

    // Phase D: redirect while WAIT, late ack carries 0xDEAD which must be dropped
    n = 0;
    while (if_gdm_en && n < 10) begin @(posedge clock); #2; n++; end
    mem_lat = 3;
    wait_new_req(base);
    hold_addr = if_gdm_addr;
    dead_next = 1'b1;
    id_if_selfontepc = 1'b1;
    id_if_seltipopc  = 2'b00;
    id_if_pcimd2ext  = 32'h100;
    id_if_rega       = $urandom;
    id_if_pcindx     = $urandom;
    @(posedge clock); #1;
    exp_q.delete();
    push_stream(32'h100);
    #1;
    id_if_selfontepc = 1'b0;
    @(negedge clock);
    check("drop_state", {62'd0, dbg_state}, 64'd2);
    check("drop_bubble_pc", {32'd0, if_id_proximopc}, 64'h100);
    for (int i = 0; i < 3; i++) begin
      check("drop_en", {63'd0, if_gdm_en}, 64'd1);
      check("drop_addr", {32'd0, if_gdm_addr}, {32'd0, hold_addr});
      @(negedge clock);
    end
    wait_req(base + 1, 32'h100, "drop_next_addr");
    repeat (20) @(posedge clock);
    check("dead_never_seen", {63'd0, dead_seen}, 64'd0);
    n = 0;
    @(posedge clock); #2;
    while (if_gdm_en && n < 10) begin @(posedge clock); #2; n++; end
    mem_lat = 0;
    repeat (4) @(posedge clock);

    // Phase E: forwarding stall holds IF/ID
    @(posedge clock); #2;
    fw_if_id_stall = 1'b1;
    @(negedge clock);
    rec_pc    = if_id_proximopc;
    rec_instr = if_id_instrucao;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #2;
      if (i == 5) fw_if_id_stall = 1'b0;
      @(negedge clock);
      check("fw_hold_pc", {32'd0, if_id_proximopc}, {32'd0, rec_pc});
      check("fw_hold_instr", {32'd0, if_id_instrucao}, {32'd0, rec_instr});
    end
    repeat (10) @(posedge clock);

    // PC wrap at the top of the address space
    redirect(2'b10, 32'hFFFF_FFFC, 1'b0, "redir_wrap", base);
    wait_delivery("wrap_deliv");
    check("wrap_pc", {32'd0, if_id_proximopc}, 64'd0);
    wait_req(base + 1, 32'h0, "wrap_addr");
    repeat (6) @(posedge clock);

    // Phase F: asynchronous reset in the middle of a WAIT
    mem_lat = 3;
    wait_new_req(base);
    #1;
    reset = 1'b1;
    #1;
    check("arst_en", {63'd0, if_gdm_en}, 64'd0);
    check("arst_addr", {32'd0, if_gdm_addr}, 64'd0);
    check("arst_pc", {32'd0, if_id_proximopc}, 64'd0);
    check("arst_instr", {32'd0, if_id_instrucao}, 64'd0);
    exp_q.delete();
    push_stream(32'h0);
    mem_lat = 0;
    repeat (2) @(posedge clock);
    #2;
    base = req_log.size();
    reset = 1'b0;
    wait_req(base, 32'h0, "post_rst_addr");
    repeat (12) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC after reset.
REQ-005 SHALL have parameter EXC_PC, default 64, target for seltipopc=11.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ex_if_stall  in  1  execute stall, bubble into IF/ID.
- fw_if_id_stall  in  1  forwarding stall, hold IF/ID.
- id_if_selfontepc  in  1  redirect request.
- id_if_seltipopc  in  2  redirect source select.
- id_if_rega  in  ADDR_W  register target.
- id_if_pcimd2ext  in  ADDR_W  immediate-relative target.
- id_if_pcindx  in  ADDR_W  index target.
- if_id_proximopc  out  ADDR_W  PC+4 of delivered instruction.
- if_id_instrucao  out  DATA_W  delivered instruction (0 = bubble).
- if_gdm_en  out  1  memory request.
- if_gdm_addr  out  ADDR_W  request address.
- gdm_if_ack  in  1  request completed this cycle.
- gdm_if_data  in  DATA_W  read data, valid with ack.

Function
REQ-007 SHALL run FSM IDLE/WAIT/DROP: IDLE->WAIT issues a request when no redirect and count+outstanding<DEPTH.
REQ-008 SHALL hold if_gdm_en=1 and if_gdm_addr=PC stable in WAIT until an ack cycle; the next request starts no earlier than the cycle after ack.
REQ-009 SHALL, on ack in WAIT, push {PC+4, gdm_if_data}, set PC<=PC+4 (mod 2^ADDR_W), return to IDLE.
REQ-010 SHALL compute the redirect target as: 00 pcimd2ext, 01 rega, 10 pcindx, 11 EXC_PC.
REQ-011 SHALL, on redirect, set PC<=target, flush the queue, and enter DROP if in WAIT without ack (else IDLE).
REQ-012 SHALL keep the request asserted in DROP until ack, discard that data, then go IDLE.
REQ-013 SHALL, on redirect coincident with ack, discard the data.
REQ-014 SHALL update IF/ID with priority fw_if_id_stall (hold), then redirect (instr 0, proximopc=target), then ex_if_stall (instr 0, proximopc=PC), then pop head if non-empty, else bubble (instr 0, proximopc=PC).
REQ-015 SHALL not bypass the queue: data acked in cycle n reaches IF/ID outputs in cycle n+2 at earliest.
REQ-016 SHALL never overflow: outstanding request reserves a slot; pop and push in one cycle is legal when full.
REQ-017 SHALL keep fetching during either stall until the queue reaches DEPTH.
REQ-018 SHALL apply redirect to PC/queue even while fw_if_id_stall holds IF/ID.

Reset
REQ-019 SHALL, while reset=1, asynchronously force PC=RESET_PC, queue empty, FSM IDLE, if_gdm_en=0, if_gdm_addr=0, if_id_proximopc=0, if_id_instrucao=0.
REQ-020 SHALL abandon any outstanding request on reset; acks during reset are ignored.

Configuration
REQ-021 SHALL, with FETCH_PREFETCH_PERF_EN defined, add 32-bit outputs perf_fetch_cnt (acked non-discarded fetches) and perf_bubble_cnt (bubbles written to IF/ID), wrapping, reset 0.
REQ-022 SHALL, without FETCH_PREFETCH_PERF_EN, omit those ports and counters; function otherwise identical.

Structure
REQ-023 SHALL place seltipopc encodings, FSM state encoding, and default EXC_PC in shared package fetch_pkg.
REQ-024 SHALL implement the queue as sub-module fetch_queue (sync FIFO, DEPTH, width ADDR_W+DATA_W, flush input).

Verification
REQ-025 Reset release, ack same cycle, data 0x0000000B -> addrs 0,4,8,...; first IF/ID: instr 0x0B, proximopc 4.
REQ-026 ex_if_stall=1 for 8 cycles -> instr 0 each cycle, queue fills to 4, if_gdm_en low; release -> 4 back-to-back pops.
REQ-027 Redirect sel=11 -> next if_gdm_addr 64, IF/ID bubble, proximopc 64; sel=01, rega=23 -> addr 23.
REQ-028 Redirect in WAIT, ack 3 cycles later with 0xDEAD -> 0xDEAD never reaches IF/ID; next request addr = target.
REQ-029 fw_if_id_stall 6 cycles -> outputs constant; PC 0xFFFFFFFC fetch -> next addr 0, proximopc 0.
REQ-030 reset asserted mid-WAIT between edges -> all outputs 0 immediately, first post-reset addr RESET_PC.
